// File: rtl/alu_share_ctrl_pkg.sv
// Shared types and constants for the alu_share_ctrl slice: ALU op codes,
// controller FSM encoding and condition-code reset values.
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic CC_ZF_RST      = 1'b1;
  localparam logic CC_SF_RST      = 1'b0;
  localparam logic CC_OF_RST      = 1'b0;
  // Port 1 "granted last" at reset so port 0 wins the first contention.
  localparam logic LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// Combinational two's-complement ALU (module alu): add, sub, and, xor, with a
// signed-overflow flag that is only meaningful for add/sub.
module alu
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum      = a + b;
    diff     = a - b;
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      default: result = a ^ b;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one alu between the execute stage (port 0) and the
// address path (port 1). Define ALU_SHARE_CC_EN to add ZF/SF/OF condition codes.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow
`ifdef ALU_SHARE_CC_EN
  ,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
`endif
);

  state_e           state_reg, state_next;
  logic             last_grant_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             id_reg;
  logic             rsp_id_reg, rsp_overflow_reg;
  logic [WIDTH-1:0] rsp_result_reg;

  logic             grant0, grant1, accept_ok, xfer, xfer_id;
  logic [WIDTH-1:0] alu_result;
  logic             alu_overflow;

  // Ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant_reg);
    grant0     = req0_valid && !grant1;
    accept_ok  = !rst && ((state_reg == ST_IDLE) ||
                          ((state_reg == ST_DONE) && rsp_ready));
    req0_ready = grant0 && accept_ok;
    req1_ready = grant1 && accept_ok;
    xfer       = req0_ready || req1_ready;
    xfer_id    = req1_ready;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (xfer) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_DONE;
      ST_DONE: begin
        if (rsp_ready) state_next = xfer ? ST_EXEC : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      last_grant_reg   <= LAST_GRANT_RST;
      op_reg           <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      id_reg           <= 1'b0;
      rsp_id_reg       <= 1'b0;
      rsp_result_reg   <= '0;
      rsp_overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (xfer) begin
        last_grant_reg <= xfer_id;
        id_reg         <= xfer_id;
        op_reg         <= xfer_id ? req1_op : req0_op;
        a_reg          <= xfer_id ? req1_a  : req0_a;
        b_reg          <= xfer_id ? req1_b  : req0_b;
      end
      if (state_reg == ST_EXEC) begin
        rsp_id_reg       <= id_reg;
        rsp_result_reg   <= alu_result;
        rsp_overflow_reg <= alu_overflow;
      end
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .op       (op_reg),
    .a        (a_reg),
    .b        (b_reg),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  assign rsp_valid    = (state_reg == ST_DONE);
  assign rsp_id       = rsp_id_reg;
  assign rsp_result   = rsp_result_reg;
  assign rsp_overflow = rsp_overflow_reg;

`ifdef ALU_SHARE_CC_EN
  logic cc_zf_reg, cc_sf_reg, cc_of_reg;

  // Only execute-stage (port 0) results drive the architectural flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_zf_reg <= CC_ZF_RST;
      cc_sf_reg <= CC_SF_RST;
      cc_of_reg <= CC_OF_RST;
    end else if ((state_reg == ST_EXEC) && !id_reg) begin
      cc_zf_reg <= (alu_result == '0);
      cc_sf_reg <= alu_result[WIDTH-1];
      cc_of_reg <= alu_overflow;
    end
  end

  assign cc_zf = cc_zf_reg;
  assign cc_sf = cc_sf_reg;
  assign cc_of = cc_of_reg;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl; condition-code checks are compiled
// only when ALU_SHARE_CC_EN is defined.
module tb_alu_share_ctrl;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op = 2'b00, req1_op = 2'b00;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_overflow;
  logic [W-1:0] rsp_result;
`ifdef ALU_SHARE_CC_EN
  logic         cc_zf, cc_sf, cc_of;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_op      (req0_op),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_op      (req1_op),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow)
`ifdef ALU_SHARE_CC_EN
    ,
    .cc_zf        (cc_zf),
    .cc_sf        (cc_sf),
    .cc_of        (cc_of)
`endif
  );

  // Present one request, wait (bounded) for ready, let it transfer, drop valid.
  // Returns at the negedge of the EXEC cycle.
  task automatic send(input logic port, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    @(negedge clk);
    if (port) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else      begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    vec_cnt++;
    if (!(port ? req1_ready : req0_ready)) begin
      err_cnt++;
      $display("FAIL send_ready port%0d: ready=0 after %0d cycles, required 1", port, n);
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (req0_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready: got %b need 0", req0_ready); end
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b need 0", rsp_valid); end
    vec_cnt++; if (rsp_id !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_id: got %b need 0", rsp_id); end
    vec_cnt++; if (rsp_result !== '0) begin err_cnt++; $display("FAIL reset_rsp_result: got %h need 0", rsp_result); end
    vec_cnt++; if (rsp_overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_ovf: got %b need 0", rsp_overflow); end
`ifdef ALU_SHARE_CC_EN
    vec_cnt++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin err_cnt++; $display("FAIL reset_cc: zf/sf/of got %b need 100", {cc_zf, cc_sf, cc_of}); end
`endif
    req0_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_add();
    send(1'b0, 2'b00, 64'd5, 64'd7);
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL add_latency_exec: rsp_valid got %b need 0", rsp_valid); end
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL add_rsp_valid: got %b need 1", rsp_valid); end
    vec_cnt++; if (rsp_result !== 64'd12) begin err_cnt++; $display("FAIL add_result: got %h need c", rsp_result); end
    vec_cnt++; if (rsp_overflow !== 1'b0) begin err_cnt++; $display("FAIL add_ovf: got %b need 0", rsp_overflow); end
    vec_cnt++; if (rsp_id !== 1'b0) begin err_cnt++; $display("FAIL add_id: got %b need 0", rsp_id); end
`ifdef ALU_SHARE_CC_EN
    vec_cnt++; if ({cc_zf, cc_sf} !== 2'b00) begin err_cnt++; $display("FAIL add_cc: zf/sf got %b need 00", {cc_zf, cc_sf}); end
`endif
    take_rsp();
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL add_release: rsp_valid got %b need 0", rsp_valid); end
  endtask

  task automatic test_overflow();
    send(1'b0, 2'b01, 64'h8000_0000_0000_0000, 64'd1);
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (rsp_result !== 64'h7FFF_FFFF_FFFF_FFFF) begin err_cnt++; $display("FAIL sub_ovf_result: got %h need 7fffffffffffffff", rsp_result); end
    vec_cnt++; if (rsp_overflow !== 1'b1) begin err_cnt++; $display("FAIL sub_ovf_flag: got %b need 1", rsp_overflow); end
`ifdef ALU_SHARE_CC_EN
    vec_cnt++; if ({cc_zf, cc_sf, cc_of} !== 3'b001) begin err_cnt++; $display("FAIL sub_ovf_cc: zf/sf/of got %b need 001", {cc_zf, cc_sf, cc_of}); end
`endif
    take_rsp();
    send(1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (rsp_result !== 64'h8000_0000_0000_0000) begin err_cnt++; $display("FAIL add_ovf_result: got %h need 8000000000000000", rsp_result); end
    vec_cnt++; if (rsp_overflow !== 1'b1) begin err_cnt++; $display("FAIL add_ovf_flag: got %b need 1", rsp_overflow); end
`ifdef ALU_SHARE_CC_EN
    vec_cnt++; if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin err_cnt++; $display("FAIL add_ovf_cc: zf/sf/of got %b need 011", {cc_zf, cc_sf, cc_of}); end
`endif
    take_rsp();
    send(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_F0F0, 64'hFFFF_FFFF_FFFF_FF00);
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (rsp_result !== 64'hFFFF_FFFF_FFFF_F000) begin err_cnt++; $display("FAIL and_result: got %h need fffffffffffff000", rsp_result); end
    vec_cnt++; if (rsp_overflow !== 1'b0) begin err_cnt++; $display("FAIL and_ovf: got %b need 0", rsp_overflow); end
    take_rsp();
  endtask

  task automatic test_port1_cc();
    send(1'b0, 2'b00, 64'd1, 64'd1);
    @(posedge clk); @(negedge clk);
    take_rsp();
    send(1'b1, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (rsp_id !== 1'b1) begin err_cnt++; $display("FAIL p1_id: got %b need 1", rsp_id); end
    vec_cnt++; if (rsp_result !== '0) begin err_cnt++; $display("FAIL p1_xor_result: got %h need 0", rsp_result); end
    vec_cnt++; if (rsp_overflow !== 1'b0) begin err_cnt++; $display("FAIL p1_xor_ovf: got %b need 0", rsp_overflow); end
`ifdef ALU_SHARE_CC_EN
    vec_cnt++; if ({cc_zf, cc_sf, cc_of} !== 3'b000) begin err_cnt++; $display("FAIL p1_cc_unchanged: zf/sf/of got %b need 000", {cc_zf, cc_sf, cc_of}); end
`endif
    take_rsp();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_res [6];
    logic         exp_id  [6];
    int i0, i1, k, cyc, last_cyc;
    logic r0, r1;
    exp_res = '{64'd10, 64'd99, 64'd21, 64'd98, 64'd32, 64'd97};
    exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rsp_ready  = 1'b1;
    i0 = 0; i1 = 0; k = 0; cyc = 0; last_cyc = 0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 64'd10; req0_b = 64'd0;
    req1_valid = 1'b1; req1_op = 2'b01; req1_a = 64'd100; req1_b = 64'd1;
    while (k < 6 && cyc < 40) begin
      #1;
      r0 = req0_ready; r1 = req1_ready;
      if (rsp_valid) begin
        vec_cnt++;
        if (rsp_id !== exp_id[k] || rsp_result !== exp_res[k]) begin
          err_cnt++;
          $display("FAIL rr_rsp%0d: id/result got %b/%0d need %b/%0d", k, rsp_id, rsp_result, exp_id[k], exp_res[k]);
        end
        if (k > 0) begin
          vec_cnt++;
          if (cyc - last_cyc != 2) begin
            err_cnt++;
            $display("FAIL rr_spacing%0d: got %0d cycles need 2", k, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        k++;
      end
      @(negedge clk);
      cyc++;
      if (r0) begin
        i0++;
        if (i0 < 3) begin req0_a = 64'(10 * (i0 + 1)); req0_b = 64'(i0); end
        else req0_valid = 1'b0;
      end
      if (r1) begin
        i1++;
        if (i1 < 3) req1_b = 64'(i1 + 1);
        else req1_valid = 1'b0;
      end
    end
    vec_cnt++;
    if (k != 6) begin err_cnt++; $display("FAIL rr_timeout: got %0d responses need 6", k); end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    send(1'b0, 2'b00, 64'd40, 64'd2);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 64'd3; req1_b = 64'd6;
    for (int c = 0; c < 5; c++) begin
      #1;
      vec_cnt++;
      if (req1_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 64'd42 || rsp_id !== 1'b0) begin
        err_cnt++;
        $display("FAIL stall_c%0d: ready/valid/result/id got %b/%b/%0d/%b need 0/1/42/0", c, req1_ready, rsp_valid, rsp_result, rsp_id);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    vec_cnt++; if (req1_ready !== 1'b1) begin err_cnt++; $display("FAIL stall_release_ready: got %b need 1", req1_ready); end
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0; rsp_ready = 1'b0;
    vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL stall_b2b_exec: rsp_valid got %b need 0", rsp_valid); end
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 64'd5) begin
      err_cnt++; $display("FAIL stall_p1_rsp: valid/id/result got %b/%b/%0d need 1/1/5", rsp_valid, rsp_id, rsp_result);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid();
    send(1'b0, 2'b00, 64'd2, 64'd3);
    rst = 1'b1;
    #1;
    vec_cnt++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b0) begin err_cnt++; $display("FAIL rstmid_outputs: valid/ready got %b/%b need 0/0", rsp_valid, req0_ready); end
`ifdef ALU_SHARE_CC_EN
    vec_cnt++; if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin err_cnt++; $display("FAIL rstmid_cc: zf/sf/of got %b need 100", {cc_zf, cc_sf, cc_of}); end
`endif
    @(negedge clk); rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_no_rsp: rsp_valid got %b need 0", rsp_valid); end
    end
    send(1'b0, 2'b01, 64'd9, 64'd4);
    @(posedge clk); @(negedge clk);
    vec_cnt++; if (rsp_valid !== 1'b1 || rsp_result !== 64'd5 || rsp_id !== 1'b0) begin
      err_cnt++; $display("FAIL rstmid_next: valid/result/id got %b/%0d/%b need 1/5/0", rsp_valid, rsp_result, rsp_id);
    end
    take_rsp();
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_port1_cc();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
